joy_db15_tx: RTL and testbench

// - Responder (adapter) end of the UserIO DB15 serial joystick link; emulates the two-player 74HC165 shift chain.
// - Latches two 12-bit button words on LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge.
// - Used for board loopback and bench-test of the DB15 reader, and as a core-side adapter stand-in.
// - Wire inputs are asynchronous and are synchronised into CLK_VIDEO.

---
 rtl/joy_db15_tx.sv | 169 ++++++++++++++++
 tb/tb_joy_db15_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// Responder end of the DB15 serial joystick link: emulates the two-player 74HC165 chain.
// Optional build macro JOY_DB15_TX_STATS_EN adds frame_cnt/err_cnt statistics outputs.
module joy_db15_tx #(
   parameter int PBITS   = 12,
   parameter int TIMEOUT = 4096
) (
   input  logic             CLK_VIDEO,
   input  logic             reset,
   input  logic [PBITS-1:0] joy1_in,
   input  logic [PBITS-1:0] joy2_in,
   input  logic             joy_clk_in,
   input  logic             joy_load_in,
   output logic             joy_data_out,
   output logic             busy,
   output logic             frame_done,
   output logic             err_abort
`ifdef JOY_DB15_TX_STATS_EN
   ,
   output logic [15:0]      frame_cnt,
   output logic [7:0]       err_cnt
`endif
);

   localparam int NBITS = 2 * PBITS;
   localparam int CW    = $clog2(NBITS);
   localparam int TW    = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             frameDone_q, frameDone_d;
   logic             errAbort_q, errAbort_d;
   logic [1:0]       clkSync_q, loadSync_q;
   logic             clkHist_q, loadHist_q;

   logic             clkS, loadS, clkRise, loadEdge, timeout, active;
   logic [NBITS-1:0] loadWord;

   // Synchronisers reset high so the idle wire levels never look like an edge.
   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         clkSync_q  <= 2'b11;
         loadSync_q <= 2'b11;
         clkHist_q  <= 1'b1;
         loadHist_q <= 1'b1;
      end else begin
         clkSync_q  <= {clkSync_q[0], joy_clk_in};
         loadSync_q <= {loadSync_q[0], joy_load_in};
         clkHist_q  <= clkSync_q[1];
         loadHist_q <= loadSync_q[1];
      end
   end

   assign clkS     = clkSync_q[1];
   assign loadS    = loadSync_q[1];
   assign clkRise  = clkS & ~clkHist_q;
   assign loadEdge = loadS ^ loadHist_q;
   assign active   = (state_q == SHIFT) || (state_q == DONE);
   assign timeout  = active && !clkRise && !loadEdge && (tcnt_q == TW'(TIMEOUT - 1));
   assign loadWord = {~joy2_in, ~joy1_in};

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         state_q     <= IDLE;
         shreg_q     <= '1;
         bitcnt_q    <= '0;
         tcnt_q      <= '0;
         frameDone_q <= 1'b0;
         errAbort_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         tcnt_q      <= tcnt_d;
         frameDone_q <= frameDone_d;
         errAbort_q  <= errAbort_d;
      end
   end

   // A low LOAD level is checked before clock edges so LOAD always wins a tie.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      frameDone_d = 1'b0;
      errAbort_d  = 1'b0;
      tcnt_d      = tcnt_q;

      if (!active || clkRise || loadEdge)
         tcnt_d = '0;
      else if (tcnt_q != TW'(TIMEOUT - 1))
         tcnt_d = tcnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (!loadS) begin
               state_d = LATCHED;
               shreg_d = loadWord;
            end
         end
         LATCHED: begin
            if (!loadS) begin
               shreg_d = loadWord;
            end else begin
               state_d  = SHIFT;
               bitcnt_d = '0;
            end
         end
         SHIFT: begin
            if (!loadS) begin
               state_d    = LATCHED;
               shreg_d    = loadWord;
               errAbort_d = 1'b1;
            end else if (clkRise) begin
               shreg_d  = {1'b1, shreg_q[NBITS-1:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == CW'(NBITS - 1)) begin
                  state_d     = DONE;
                  frameDone_d = 1'b1;
               end
            end else if (timeout) begin
               state_d    = IDLE;
               shreg_d    = '1;
               errAbort_d = 1'b1;
            end
         end
         DONE: begin
            if (!loadS) begin
               state_d = LATCHED;
               shreg_d = loadWord;
            end else if (timeout) begin
               state_d = IDLE;
               shreg_d = '1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign joy_data_out = (state_q == DONE) ? 1'b1 : shreg_q[0];
   assign busy         = (state_q == LATCHED) || (state_q == SHIFT);
   assign frame_done   = frameDone_q;
   assign err_abort    = errAbort_q;

`ifdef JOY_DB15_TX_STATS_EN
   logic [15:0] frameCnt_q;
   logic [7:0]  errCnt_q;

   // Frame count wraps; error count sticks at its maximum.
   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         frameCnt_q <= '0;
         errCnt_q   <= '0;
      end else begin
         if (frameDone_q)
            frameCnt_q <= frameCnt_q + 16'd1;
         if (errAbort_q && errCnt_q != 8'hFF)
            errCnt_q <= errCnt_q + 8'd1;
      end
   end

   assign frame_cnt = frameCnt_q;
   assign err_cnt   = errCnt_q;
`endif

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: drives the DB15 wires like a reader and checks the serial bits.
// Build with JOY_DB15_TX_STATS_EN defined to also exercise the statistics counters.
module tb_joy_db15_tx;

   localparam int PBITS   = 12;
   localparam int TIMEOUT = 64;

   logic             CLK_VIDEO = 1'b0;
   logic             reset;
   logic [PBITS-1:0] joy1, joy2;
   logic             joyClk, joyLoad;
   logic             joyData, busy, frameDone, errAbort;
`ifdef JOY_DB15_TX_STATS_EN
   logic [15:0]      frameCnt;
   logic [7:0]       errCnt;
`endif

   int assertCount = 0;
   int failCount   = 0;
   int donePulses  = 0;
   int errPulses   = 0;
   logic [2*PBITS-1:0] expWord;

   joy_db15_tx #(.PBITS(PBITS), .TIMEOUT(TIMEOUT)) dut (
      .CLK_VIDEO   (CLK_VIDEO),
      .reset       (reset),
      .joy1_in     (joy1),
      .joy2_in     (joy2),
      .joy_clk_in  (joyClk),
      .joy_load_in (joyLoad),
      .joy_data_out(joyData),
      .busy        (busy),
      .frame_done  (frameDone),
      .err_abort   (errAbort)
`ifdef JOY_DB15_TX_STATS_EN
      ,
      .frame_cnt   (frameCnt),
      .err_cnt     (errCnt)
`endif
   );

   always #5 CLK_VIDEO = ~CLK_VIDEO;

   // Pulse outputs are tallied on the falling edge, away from register updates.
   always @(negedge CLK_VIDEO) begin
      if (frameDone) donePulses++;
      if (errAbort)  errPulses++;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge CLK_VIDEO);
      #1;
   endtask

   task automatic applyStimulus(input logic clkLevel, input logic loadLevel, input int cycles);
      joyClk  = clkLevel;
      joyLoad = loadLevel;
      waitCycles(cycles);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic loadFrame(input logic [PBITS-1:0] j1, input logic [PBITS-1:0] j2);
      joy1 = j1;
      joy2 = j2;
      applyStimulus(1'b0, 1'b0, 8);
      applyStimulus(1'b0, 1'b1, 4);
   endtask

   task automatic clockBit();
      applyStimulus(1'b1, 1'b1, 4);
      applyStimulus(1'b0, 1'b1, 4);
   endtask

   initial begin
      reset   = 1'b1;
      joyClk  = 1'b0;
      joyLoad = 1'b1;
      joy1    = '0;
      joy2    = '0;
      waitCycles(3);
      checkOutput("reset_data", {31'd0, joyData}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, frameDone}, 32'd0);
      checkOutput("reset_err", {31'd0, errAbort}, 32'd0);
      reset = 1'b0;
      waitCycles(2);

      // T1: reset in the middle of a shift
      loadFrame(12'h005, 12'h800);
      for (int i = 0; i < 3; i++) clockBit();
      checkOutput("t1_busy_pre", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      waitCycles(3);
      checkOutput("t1_data", {31'd0, joyData}, 32'd1);
      checkOutput("t1_busy", {31'd0, busy}, 32'd0);
      checkOutput("t1_done_pulses", donePulses, 32'd0);
      checkOutput("t1_err_pulses", errPulses, 32'd0);
      reset = 1'b0;
      waitCycles(5);
      checkOutput("t1_idle_data", {31'd0, joyData}, 32'd1);
      checkOutput("t1_idle_busy", {31'd0, busy}, 32'd0);

      // T2: full frame; inputs changed after latching must not leak in
      loadFrame(12'h005, 12'h800);
      joy1 = 12'hFFF;
      joy2 = 12'h000;
      expWord = 24'h7FFFFA;
      checkOutput("t2_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 24; i++) begin
         checkOutput($sformatf("t2_bit%0d", i), {31'd0, joyData}, {31'd0, expWord[i]});
         clockBit();
      end
      checkOutput("t2_done_pulses", donePulses, 32'd1);
      checkOutput("t2_busy_after", {31'd0, busy}, 32'd0);
      checkOutput("t2_data_after", {31'd0, joyData}, 32'd1);

      // T3: overclocking past the frame end
      loadFrame(12'h0F0, 12'h00F);
      expWord = 24'hFF0F0F;
      for (int i = 0; i < 30; i++) begin
         if (i < 24) begin
            checkOutput($sformatf("t3_bit%0d", i), {31'd0, joyData}, {31'd0, expWord[i]});
         end else begin
            checkOutput($sformatf("t3_extra%0d", i), {31'd0, joyData}, 32'd1);
            if (i == 24) begin
               checkOutput("t3_busy_done", {31'd0, busy}, 32'd0);
               checkOutput("t3_done_pulses_24", donePulses, 32'd2);
            end
         end
         clockBit();
      end
      checkOutput("t3_done_pulses", donePulses, 32'd2);
      waitCycles(TIMEOUT + 8);
      checkOutput("t3_done_timeout_err", errPulses, 32'd0);
      checkOutput("t3_idle_data", {31'd0, joyData}, 32'd1);

      // T4: LOAD re-asserted mid-frame
      loadFrame(12'h123, 12'h456);
      expWord = 24'hBA9EDC;
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("t4a_bit%0d", i), {31'd0, joyData}, {31'd0, expWord[i]});
         clockBit();
      end
      loadFrame(12'h0A0, 12'h001);
      checkOutput("t4_err_pulses", errPulses, 32'd1);
      checkOutput("t4_busy", {31'd0, busy}, 32'd1);
      expWord = 24'hFFEF5F;
      for (int i = 0; i < 24; i++) begin
         checkOutput($sformatf("t4b_bit%0d", i), {31'd0, joyData}, {31'd0, expWord[i]});
         if (i == 23) checkOutput("t4_no_early_done", donePulses, 32'd2);
         clockBit();
      end
      checkOutput("t4_done_pulses", donePulses, 32'd3);

      // T5: clock stalls mid-frame until the timeout fires
      loadFrame(12'h001, 12'h000);
      expWord = 24'hFFFFFE;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("t5_bit%0d", i), {31'd0, joyData}, {31'd0, expWord[i]});
         clockBit();
      end
      applyStimulus(1'b0, 1'b1, TIMEOUT - 10);
      checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
      checkOutput("t5_err_before", errPulses, 32'd1);
      applyStimulus(1'b0, 1'b1, 12);
      checkOutput("t5_err_pulses", errPulses, 32'd2);
      checkOutput("t5_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_data", {31'd0, joyData}, 32'd1);

`ifdef JOY_DB15_TX_STATS_EN
      // T6: statistics counters, including saturation of the error count
      waitCycles(2);
      checkOutput("t6_frame_cnt", {16'd0, frameCnt}, 32'd3);
      checkOutput("t6_err_cnt", {24'd0, errCnt}, 32'd2);
      for (int i = 0; i < 301; i++) begin
         applyStimulus(1'b0, 1'b0, 4);
         applyStimulus(1'b0, 1'b1, 4);
      end
      waitCycles(4);
      checkOutput("t6_err_pulses", errPulses, 32'd302);
      checkOutput("t6_err_cnt_sat", {24'd0, errCnt}, 32'd255);
      checkOutput("t6_frame_cnt_hold", {16'd0, frameCnt}, 32'd3);
`endif

      waitCycles(2);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
